// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Host-to-device half of the PS/2 link. Sends one command byte to the
//   mouse using the request-to-send sequence. The byte goes out as a 10-bit
//   frame, LSB first: data, odd parity, stop. The module then checks the
//   device's acknowledge bit. The two drive_low outputs feed open-drain
//   pads at the top level.
//
// Ports
//   i_clock                system clock (50 MHz)
//   i_reset                synchronous, active-high reset
//   i_start                single-cycle request, sampled only in IDLE
//   i_data_in[7:0]         command byte, latched on an accepted start
//   i_ps2_clock_in         raw mouse_clock line
//   i_ps2_data_in          raw mouse_data line
//   o_ps2_clock_drive_low  1 = pull mouse_clock low
//   o_ps2_data_drive_low   1 = pull mouse_data low
//   o_busy                 transfer in progress
//   o_done                 one-cycle pulse: byte sent, ack = 0 received
//   o_error                one-cycle pulse: timeout or ack sampled high
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LENGTH  = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data_in,
    input  logic       i_ps2_clock_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clock_drive_low,
    output logic       o_ps2_data_drive_low,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FLT_W = (FILTER_LENGTH  > 1) ? $clog2(FILTER_LENGTH)  : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SEND,
        S_ACK,
        S_RELEASE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Input conditioning
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_filt;
    logic [FLT_W-1:0] r_filt_cnt;
    logic             r_clk_fall;

    // Transfer datapath
    logic [9:0]       r_frame;
    logic [3:0]       r_bit_cnt;
    logic             r_tx_low;
    logic [INH_W-1:0] r_inhibit_cnt;
    logic [TO_W-1:0]  r_timeout_cnt;

    logic w_data_sync;
    logic w_timeout;
    logic w_timing;

    assign w_data_sync = r_data_sync[1];
    assign w_timeout   = (r_timeout_cnt == TO_LAST);
    assign w_timing    = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_RELEASE);

    // The filter counts consecutive samples that disagree with the filtered
    // value. Any agreeing sample restarts the count, so a pulse shorter than
    // FILTER_LENGTH never reaches the filtered clock. r_clk_fall is set in
    // the same cycle that r_clk_filt drops to 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_clk_fall  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clock_in};
            r_data_sync <= {r_data_sync[0], i_ps2_data_in};
            r_clk_fall  <= 1'b0;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FLT_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
                r_clk_fall <= r_clk_filt;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. The timeout has priority over every other event.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (r_inhibit_cnt == INH_LAST) w_next_state = S_REQUEST;
            end
            S_REQUEST: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (w_timeout)                              w_next_state = S_FAIL;
                else if (r_clk_fall && (r_bit_cnt == 4'd9)) w_next_state = S_ACK;
            end
            S_ACK: begin
                if (w_timeout)       w_next_state = S_FAIL;
                else if (r_clk_fall) w_next_state = w_data_sync ? S_FAIL : S_RELEASE;
            end
            S_RELEASE: begin
                if (w_timeout)                       w_next_state = S_FAIL;
                else if (r_clk_filt && w_data_sync)  w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            S_FAIL:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: frame latch and shift, bit counter, phase counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frame       <= '0;
            r_bit_cnt     <= '0;
            r_tx_low      <= 1'b0;
            r_inhibit_cnt <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_inhibit_cnt <= (r_state == S_INHIBIT) ? r_inhibit_cnt + 1'b1 : '0;
            r_timeout_cnt <= w_timing ? r_timeout_cnt + 1'b1 : '0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_frame <= {1'b1, ~^i_data_in, i_data_in};
                end
                S_REQUEST: begin
                    // Start bit stays on the line until the first device edge
                    r_tx_low  <= 1'b1;
                    r_bit_cnt <= '0;
                end
                S_SEND: begin
                    if (r_clk_fall) begin
                        r_tx_low  <= ~r_frame[0];
                        r_frame   <= {1'b0, r_frame[9:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_ps2_clock_drive_low = 1'b0;
        o_ps2_data_drive_low  = 1'b0;
        o_busy                = 1'b0;
        o_done                = 1'b0;
        o_error               = 1'b0;
        case (r_state)
            S_INHIBIT: begin
                o_ps2_clock_drive_low = 1'b1;
                o_busy                = 1'b1;
            end
            S_REQUEST: begin
                o_ps2_clock_drive_low = 1'b1;
                o_ps2_data_drive_low  = 1'b1;
                o_busy                = 1'b1;
            end
            S_SEND: begin
                o_ps2_data_drive_low = r_tx_low;
                o_busy               = 1'b1;
            end
            S_ACK:     o_busy  = 1'b1;
            S_RELEASE: o_busy  = 1'b1;
            S_DONE:    o_done  = 1'b1;
            S_FAIL:    o_error = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb_ps2_host_transmitter
//   Testbench for ps2_host_transmitter. Expected results go into a
//   scoreboard queue when a transfer is started. A monitor pops one entry
//   on every done/error pulse and compares against it. A behavioural PS/2
//   device model supplies the clock, captures the frame and drives the ack.
module tb_ps2_host_transmitter;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_data_in;
    logic       o_clk_dl;
    logic       o_data_dl;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    logic       dev_clk_low;
    logic       dev_data_low;
    logic [9:0] dev_frame;
    logic       line_clk;
    logic       line_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit         is_err;
        bit         chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t exp_q[$];

    // Open-drain wired-AND of host and device
    assign line_clk  = ~(o_clk_dl | dev_clk_low);
    assign line_data = ~(o_data_dl | dev_data_low);

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(4000),
        .FILTER_LENGTH (4)
    ) dut (
        .i_clock              (clk),
        .i_reset              (i_reset),
        .i_start              (i_start),
        .i_data_in            (i_data_in),
        .i_ps2_clock_in       (line_clk),
        .i_ps2_data_in        (line_data),
        .o_ps2_clock_drive_low(o_clk_dl),
        .o_ps2_data_drive_low (o_data_dl),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_error              (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input string name, input bit is_err, input bit chk_frame,
                            input logic [9:0] frame);
        exp_t e;
        e.name      = name;
        e.is_err    = is_err;
        e.chk_frame = chk_frame;
        e.frame     = frame;
        exp_q.push_back(e);
    endtask

    // Monitor: every done/error pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!i_reset && (o_done || o_error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({o_done, o_error}), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_kind"}, 32'({o_done, o_error}),
                      32'(e.is_err ? 2'b01 : 2'b10));
                check({e.name, "_busy_low"}, 32'(o_busy), 32'(0));
                check({e.name, "_lines_released"}, 32'({o_clk_dl, o_data_dl}), 32'(0));
                if (e.chk_frame) check({e.name, "_frame"}, 32'(dev_frame), 32'(e.frame));
            end
        end
    end

    task automatic issue_start(input logic [7:0] d);
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        i_data_in = d;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_data_in = ~d;
    endtask

    // Device model: 200-cycle clock period, samples data at the end of each
    // low phase. last_bit < 9 abandons the frame after that bit.
    task automatic device_xfer(input bit do_ack, input int glitch_bit, input int last_bit);
        int n;
        dev_frame = '0;
        n = 0;
        while (!(!o_clk_dl && o_data_dl) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dev_sees_request", 32'(!o_clk_dl && o_data_dl), 32'(1));
        repeat (50) @(negedge clk);
        for (int i = 0; i <= last_bit; i++) begin
            dev_clk_low = 1'b1;
            repeat (100) @(negedge clk);
            dev_frame[i[3:0]] = line_data;
            dev_clk_low = 1'b0;
            if (i == glitch_bit) begin
                repeat (40) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (58) @(negedge clk);
            end else if (i == 9) begin
                repeat (20) @(negedge clk);
                dev_data_low = do_ack;
                repeat (80) @(negedge clk);
            end else begin
                repeat (100) @(negedge clk);
            end
        end
        if (last_bit == 9) begin
            dev_clk_low = 1'b1;
            repeat (100) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'(0));
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int n;
        int m;
        int viol;
        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_data_in    = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({o_clk_dl, o_data_dl, o_busy, o_done, o_error}), 32'(0));
        i_reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_outputs", 32'({o_clk_dl, o_data_dl, o_busy, o_done, o_error}), 32'(0));

        // Nominal 0xF4: frame bits 0,0,1,0,1,1,1,1, parity 0, stop 1
        push_exp("nominal", 1'b0, 1'b1, 10'h2F4);
        issue_start(8'hF4);
        @(negedge clk);
        check("busy_after_start", 32'(o_busy), 32'(1));
        n = 0;
        while (o_clk_dl && !o_data_dl && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", 32'(n), 32'(20));
        m = 0;
        while (o_clk_dl && o_data_dl && m < 100) begin
            m++;
            @(negedge clk);
        end
        check("request_cycles", 32'(m), 32'(1));
        check("send_entry_lines", 32'({o_clk_dl, o_data_dl}), 32'(2'b01));
        device_xfer(1'b1, -1, 9);
        wait_drain("nominal");

        // Parity with all-zero data: parity bit 1
        push_exp("parity00", 1'b0, 1'b1, 10'h300);
        issue_start(8'h00);
        device_xfer(1'b1, -1, 9);
        wait_drain("parity00");

        // NACK: device leaves data high at the ack edge
        push_exp("nack", 1'b1, 1'b1, 10'h3FF);
        issue_start(8'hFF);
        device_xfer(1'b0, -1, 9);
        wait_drain("nack");

        // Timeout: device never clocks
        push_exp("timeout", 1'b1, 1'b0, 10'h000);
        issue_start(8'hF4);
        n = 0;
        while (!(!o_clk_dl && o_data_dl) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_send_entry", 32'(!o_clk_dl && o_data_dl), 32'(1));
        n = 0;
        viol = 0;
        while (!o_error && n < 5000) begin
            if (o_clk_dl) viol++;
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(4000));
        check("timeout_clk_released", 32'(viol), 32'(0));
        wait_drain("timeout");

        // Glitch: 2-cycle low pulse during a high phase must not advance a bit
        push_exp("glitch", 1'b0, 1'b1, 10'h35A);
        issue_start(8'h5A);
        device_xfer(1'b1, 3, 9);
        wait_drain("glitch");

        // Reset after the 5th data bit: lines released, no done/error
        issue_start(8'h3C);
        device_xfer(1'b1, -1, 4);
        check("busy_before_reset", 32'(o_busy), 32'(1));
        i_reset = 1'b1;
        @(negedge clk);
        check("reset_mid_lines", 32'({o_clk_dl, o_data_dl}), 32'(0));
        check("reset_mid_pulses", 32'({o_busy, o_done, o_error}), 32'(0));
        i_reset = 1'b0;
        repeat (300) @(negedge clk);
        check("reset_no_pending", 32'(exp_q.size()), 32'(0));

        // Start while busy is ignored; first byte completes unchanged
        push_exp("busy_ignore", 1'b0, 1'b1, 10'h3A5);
        issue_start(8'hA5);
        repeat (5) @(negedge clk);
        issue_start(8'h00);
        device_xfer(1'b1, -1, 9);
        wait_drain("busy_ignore");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link. It sends one command byte to the mouse, such as 0xF4 (enable data reporting) or 0xFF (reset), using the PS/2 request-to-send sequence, then checks the device's acknowledge bit. It sits beside mouse_controller on the 50 MHz domain and shares the mouse_clock/mouse_data lines. The top level builds the open-drain drivers from the two drive_low outputs.

Parameters:
INHIBIT_CYCLES, 5000, number of clock cycles ps2 clock is held low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from releasing ps2 clock to the end of the ack/release phase (15 ms).
FILTER_LENGTH, 8, number of consecutive equal synchronised samples needed before the filtered ps2 clock changes.

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
start  input  1  single-cycle request; sampled only in IDLE
data_in  input  8  command byte; latched on accepted start
ps2_clock_in  input  1  raw mouse_clock line value
ps2_data_in  input  1  raw mouse_data line value
ps2_clock_drive_low  output  1  1 = pull mouse_clock low, 0 = release
ps2_data_drive_low  output  1  1 = pull mouse_data low, 0 = release
busy  output  1  high from the cycle after an accepted start until the cycle done/error pulses
done  output  1  one-cycle pulse: byte sent and ack = 0 received
error  output  1  one-cycle pulse: timeout, or ack sampled high

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, filtered clock = 1. Reset mid-transfer releases both lines on the next edge and emits no done/error.
- Input conditioning: ps2_clock_in passes through 2 flip-flops. The filtered value updates after FILTER_LENGTH consecutive identical samples. A falling edge is filtered 1 to 0. ps2_data_in passes through 2 flip-flops only.
- Parity is odd: parity = ~^data_in.
- Frame shift register holds 10 bits, sent LSB first: data[0..7], parity, stop = 1.
- IDLE:
  - start = 1 latches data_in and moves to INHIBIT.
  - busy = 1 from the next cycle.
- INHIBIT: clock_drive_low = 1 and data_drive_low = 0 for exactly INHIBIT_CYCLES cycles, then REQUEST.
- REQUEST (1 cycle): clock_drive_low = 1 and data_drive_low = 1 (start bit), then SEND.
- SEND:
  - clock_drive_low = 0; timeout counter starts at 0.
  - On each filtered falling edge, drive the next frame bit. data_drive_low = ~bit, so a stop bit releases the line.
  - After the 10th edge (stop bit driven), go to ACK.
- ACK:
  - data_drive_low = 0.
  - On the next falling edge, sample synchronised data.
  - 0 moves to RELEASE. 1 moves to FAIL.
- RELEASE: wait until the filtered clock and synchronised data are both 1, then DONE.
- DONE: done = 1 and busy = 0 in the same cycle, then IDLE.
- FAIL: error = 1 and busy = 0 in the same cycle, then IDLE. Both lines are released.
- Timeout:
  - The counter runs in SEND, ACK and RELEASE.
  - Reaching TIMEOUT_CYCLES - 1 moves to FAIL, whatever other event happens that cycle.
- Edge cases:
  - start while busy is ignored, and data_in is not re-latched.
  - Falling edges seen in IDLE, INHIBIT or REQUEST are ignored.
  - done and error are never both 1.
  - A new start is accepted in the cycle after done/error.

Test Plan:
- Nominal, using INHIBIT_CYCLES=20, FILTER_LENGTH=4, TIMEOUT_CYCLES=4000. Assert start with data_in = 0xF4.
  - Required: clock_drive_low high for exactly 20 cycles, then 1 REQUEST cycle with both drive_low high, then clock released.
  - A device model clocking at a 200-cycle period sees data bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - The model drives ack = 0: done pulses once and busy falls in the same cycle.
- Parity, with data_in = 0x00: parity bit = 1 and ack OK, so done.
- NACK: device model leaves data high at the 11th falling edge. Required: error pulses 1 cycle, done stays 0, both drive_low = 0.
- Timeout, TIMEOUT_CYCLES=4000: device model never clocks after the request. Required: error pulses exactly 4000 cycles after SEND entry, and ps2_clock_drive_low = 0 throughout SEND.
- Glitch rejection: inject a 2-cycle low pulse on ps2_clock_in during SEND. Required: no bit advance, and the frame still completes correctly.
- Reset and busy:
  - Assert reset after the 5th data bit. Both drive_low = 0 on the next cycle, with no done/error.
  - A start issued while busy is ignored: the first byte completes unchanged.
